// File: rtl/fifo_pkg.sv
// Types shared between the synchronous FIFO and its read-side adapter.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned SKID_DEPTH = 2;

    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [1:0]            occ_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry buffer that catches FIFO read data one cycle after the grant and
// presents the oldest entry at its head.
module fifo_rd_skid #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_wr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic                  i_pop,
    output fifo_pkg::occ_t        o_occ,
    output logic [DATA_WIDTH-1:0] o_data
);

    logic [DATA_WIDTH-1:0] r_mem [fifo_pkg::SKID_DEPTH];
    logic                  r_head;
    logic                  r_tail;
    fifo_pkg::occ_t        r_occ;
    fifo_pkg::occ_t        w_occ_nxt;

    // Upstream credit keeps this within 0..2, so no saturation is needed.
    always_comb begin
        w_occ_nxt = r_occ + {1'b0, i_wr} - {1'b0, i_pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_head   <= 1'b0;
            r_tail   <= 1'b0;
            r_occ    <= '0;
        end else begin
            if (i_wr) begin
                r_mem[r_tail] <= i_wdata;
                r_tail        <= ~r_tail;
            end
            if (i_pop) begin
                r_head <= ~r_head;
            end
            r_occ <= w_occ_nxt;
        end
    end

    assign o_occ  = r_occ;
    assign o_data = r_mem[r_head];

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains the synchronous FIFO through credit-limited read strobes and offers
// the popped words as a valid/ready stream.
module fifo_rd_adapter #(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  word_cnt
);

    logic                 r_inflight;
    logic [CNT_WIDTH-1:0] r_word_cnt;
    fifo_pkg::occ_t       w_occ;
    logic                 w_pop;
    logic [2:0]           w_level;

    assign m_valid = (w_occ != 2'd0);
    assign w_pop   = m_valid && m_ready;

    // Level after this edge if nothing new is granted; pop implies occ >= 1.
    assign w_level    = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign fifo_rd_en = en && !fifo_empty && (w_level < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_inflight <= fifo_rd_en;
            if (w_pop) begin
                r_word_cnt <= r_word_cnt + 1'b1;
            end
        end
    end

    assign word_cnt = r_word_cnt;

    fifo_rd_skid #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_wr    (r_inflight),
        .i_wdata (fifo_data),
        .i_pop   (w_pop),
        .o_occ   (w_occ),
        .o_data  (m_data)
    );

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Directed bench: a behavioural FIFO with registered read data feeds the
// adapter; a second instance with a 4-bit counter checks counter wrap.
module tb_fifo_rd_adapter;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        fifo_empty;
    logic [7:0]  fifo_data;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [15:0] word_cnt;

    logic        rd_en4;
    logic        m_valid4;
    logic [7:0]  m_data4;
    logic [3:0]  word_cnt4;

    logic [7:0]  mem [64];
    int          wr_ptr;
    int          rd_ptr;

    int          n_vec;
    int          n_err;

    fifo_rd_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt)
    );

    fifo_rd_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (rd_en4),
        .m_valid    (m_valid4),
        .m_data     (m_data4),
        .m_ready    (m_ready),
        .word_cnt   (word_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: data_out registered, shares the adapter reset.
    assign fifo_empty = (wr_ptr == rd_ptr);
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= wr_ptr;
            fifo_data <= 8'h00;
        end else if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr % 64];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr++;
    endtask

    // Inputs change 1 time unit after the edge; checks run 1 unit later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    int          got;
    int          max_occ;
    logic [7:0]  exp_d;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        wr_ptr  = 0;
        rst_n   = 1'b0;
        en      = 1'b0;
        m_ready = 1'b0;
        #12;
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'h00);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Three words, streaming at full rate.
        next_cycle();
        en = 1'b1; m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        #1;
        chk("s1_c0_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle(); #1;
        chk("s1_c1_rd_en", 32'(fifo_rd_en), 32'd1);
        chk("s1_c1_valid", 32'(m_valid), 32'd0);
        next_cycle(); #1;
        chk("s1_c2_rd_en", 32'(fifo_rd_en), 32'd1);
        chk("s1_c2_data", 32'(m_data), 32'h11);
        chk("s1_c2_valid", 32'(m_valid), 32'd1);
        next_cycle(); #1;
        chk("s1_c3_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("s1_c3_data", 32'(m_data), 32'h22);
        next_cycle(); #1;
        chk("s1_c4_data", 32'(m_data), 32'h33);
        chk("s1_c4_valid", 32'(m_valid), 32'd1);
        next_cycle(); #1;
        chk("s1_c5_valid", 32'(m_valid), 32'd0);
        chk("s1_word_cnt", 32'(word_cnt), 32'd3);

        // Backpressure: two grants only, head held, then resume same cycle.
        next_cycle();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push(8'hA0 + 8'(i));
        #1;
        chk("s2_c0_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle(); #1;
        chk("s2_c1_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle(); #1;
        chk("s2_c2_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("s2_c2_data", 32'(m_data), 32'hA1);
        next_cycle(); #1;
        chk("s2_c3_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("s2_c3_data", 32'(m_data), 32'hA1);
        next_cycle(); #1;
        chk("s2_c4_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("s2_c4_valid", 32'(m_valid), 32'd1);
        chk("s2_c4_data", 32'(m_data), 32'hA1);
        next_cycle();
        m_ready = 1'b1;
        #1;
        chk("s2_c5_rd_en", 32'(fifo_rd_en), 32'd1);
        chk("s2_c5_data", 32'(m_data), 32'hA1);
        next_cycle(); #1;
        chk("s2_c6_data", 32'(m_data), 32'hA2);
        chk("s2_c6_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle(); #1;
        chk("s2_c7_data", 32'(m_data), 32'hA3);
        chk("s2_c7_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle(); #1;
        chk("s2_c8_data", 32'(m_data), 32'hA4);
        chk("s2_c8_rd_en", 32'(fifo_rd_en), 32'd0);
        next_cycle(); #1;
        chk("s2_c9_data", 32'(m_data), 32'hA5);
        chk("s2_c9_valid", 32'(m_valid), 32'd1);
        next_cycle(); #1;
        chk("s2_c10_valid", 32'(m_valid), 32'd0);
        chk("s2_fifo_empty", 32'(fifo_empty), 32'd1);
        chk("s2_word_cnt", 32'(word_cnt), 32'd8);

        // m_ready toggling every cycle over 8 words.
        next_cycle();
        for (int i = 0; i < 8; i++) push(8'hB0 + 8'(i));
        got = 0;
        max_occ = 0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            m_ready = c[0];
            #1;
            if (int'(dut.w_occ) > max_occ) max_occ = int'(dut.w_occ);
            if (m_valid && m_ready) begin
                exp_d = 8'hB0 + 8'(got);
                chk("s3_data", 32'(m_data), 32'(exp_d));
                got++;
            end
            next_cycle();
        end
        chk("s3_all_delivered", 32'(got), 32'd8);
        chk("s3_max_occ_le2", 32'(max_occ <= 2), 32'd1);
        m_ready = 1'b1;
        #1;
        chk("s3_word_cnt", 32'(word_cnt), 32'd16);
        chk("s3_drained", 32'(m_valid), 32'd0);

        // Drop en right after a grant.
        next_cycle();
        push(8'hC1); push(8'hC2); push(8'hC3);
        #1;
        chk("s4_c0_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle();
        en = 1'b0;
        #1;
        chk("s4_c1_rd_en", 32'(fifo_rd_en), 32'd0);
        next_cycle(); #1;
        chk("s4_c2_valid", 32'(m_valid), 32'd1);
        chk("s4_c2_data", 32'(m_data), 32'hC1);
        chk("s4_c2_rd_en", 32'(fifo_rd_en), 32'd0);
        next_cycle(); #1;
        chk("s4_c3_valid", 32'(m_valid), 32'd0);
        chk("s4_c3_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("s4_fifo_holds", 32'(fifo_empty), 32'd0);
        chk("s4_word_cnt", 32'(word_cnt), 32'd17);

        // Fill buffer to 2 with C2/C3, then reset mid-stream.
        next_cycle();
        en = 1'b1; m_ready = 1'b0;
        #1;
        chk("s5_c0_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle(); #1;
        chk("s5_c1_rd_en", 32'(fifo_rd_en), 32'd1);
        next_cycle(); #1;
        next_cycle(); #1;
        chk("s5_full_valid", 32'(m_valid), 32'd1);
        chk("s5_full_data", 32'(m_data), 32'hC2);
        chk("s5_full_occ", 32'(dut.w_occ), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("s5_rst_valid", 32'(m_valid), 32'd0);
        chk("s5_rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("s5_rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("s5_rst_word_cnt4", 32'(word_cnt4), 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // 17 words: 16-bit counter reads 17, 4-bit counter wraps to 1.
        next_cycle();
        m_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'hD0 + 8'(i));
        got = 0;
        for (int c = 0; c < 60 && got < 17; c++) begin
            #1;
            if (m_valid && m_ready) begin
                exp_d = 8'hD0 + 8'(got);
                chk("s6_data", 32'(m_data), 32'(exp_d));
                got++;
            end
            next_cycle();
        end
        chk("s6_all_delivered", 32'(got), 32'd17);
        #1;
        chk("s6_word_cnt", 32'(word_cnt), 32'd17);
        chk("s6_word_cnt4", 32'(word_cnt4), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
